femtosoc_uart: RTL and testbench

FEMTOSOC_UART -- requirements
Module: femtosoc_uart

---
 rtl/femtosoc_uart.sv | 247 ++++++++++++++++++++++++
 tb/tb_femtosoc_uart.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/femtosoc_uart.sv
// Memory-mapped UART for the femtosoc iomem bus: DATA/CLKDIV/STATUS registers and a TX FIFO.
// Define FEMTOSOC_UART_RX_EN to build the receiver; otherwise uart_rx is ignored.
module femtosoc_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [15:0] CLKDIV_RESET = 16'd104,
  parameter int unsigned TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned PtrW = $clog2(TX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  logic [15:0]     clkdiv_q;
  logic            ready_q, wait_q;
  logic [31:0]     rdata_q;
  logic [7:0]      fifo_mem [TX_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_full, tx_empty, tx_idle, push, pop;
  uart_st_e        tx_st_q, tx_st_d;
  logic [15:0]     tx_cnt_q;
  logic [2:0]      tx_idx_q;
  logic [7:0]      tx_sh_q;
  logic            tx_tick;
  logic            rx_valid, rx_overrun;
  logic [7:0]      rx_byte;
  logic            sel, is_wr, off_data, off_div, off_stat, off_other, can_ack, ack, data_rd_ack;
  logic [31:0]     rd_val;
  logic            unused_wdata;

  assign unused_wdata = ^iomem_wdata[31:16];
  assign iomem_ready  = ready_q;
  assign iomem_rdata  = rdata_q;

  always_comb begin
    sel       = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    is_wr     = |iomem_wstrb;
    off_data  = iomem_addr[7:0] == 8'h00;
    off_div   = iomem_addr[7:0] == 8'h04;
    off_stat  = iomem_addr[7:0] == 8'h08;
    off_other = !(off_data || off_div || off_stat);
    // Unmapped offsets wait one cycle; DATA writes wait for a free FIFO slot.
    can_ack     = off_other ? wait_q : !(off_data && is_wr && tx_full);
    ack         = sel && !ready_q && can_ack;
    push        = ack && off_data && is_wr;
    data_rd_ack = ack && off_data && !is_wr;
    rd_val      = '0;
    if (!is_wr) begin
      if (off_data)      rd_val = rx_valid ? {24'h0, rx_byte} : 32'hFFFF_FFFF;
      else if (off_div)  rd_val = {16'h0, clkdiv_q};
      else if (off_stat) rd_val = {28'h0, rx_overrun, rx_valid, tx_idle, tx_full};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      wait_q   <= 1'b0;
      rdata_q  <= '0;
      clkdiv_q <= CLKDIV_RESET;
    end else begin
      ready_q <= ack;
      wait_q  <= sel && off_other && !ready_q && !ack;
      rdata_q <= ack ? rd_val : '0;
      if (ack && off_div && |iomem_wstrb[1:0]) begin
        clkdiv_q <= (iomem_wdata[15:0] < 16'd2) ? 16'd2 : iomem_wdata[15:0];
      end
    end
  end

  assign tx_full  = cnt_q == CntW'(TX_DEPTH);
  assign tx_empty = cnt_q == '0;
  assign pop      = (tx_st_q == StIdle) && !tx_empty;
  assign tx_idle  = tx_empty && (tx_st_q == StIdle);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= iomem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // TX: state register, next-state logic, output decode.
  always_ff @(posedge clk) begin
    if (!resetn) tx_st_q <= StIdle;
    else         tx_st_q <= tx_st_d;
  end

  assign tx_tick = tx_cnt_q == '0;

  always_comb begin
    tx_st_d = tx_st_q;
    unique case (tx_st_q)
      StIdle:  if (!tx_empty) tx_st_d = StStart;
      StStart: if (tx_tick) tx_st_d = StData;
      StData:  if (tx_tick && tx_idx_q == 3'd7) tx_st_d = StStop;
      StStop:  if (tx_tick) tx_st_d = StIdle;
      default: tx_st_d = StIdle;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (tx_st_q)
      StStart: uart_tx = 1'b0;
      StData:  uart_tx = tx_sh_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // Bit counter reloads from CLKDIV at every boundary, so divider changes apply per bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
    end else if (pop) begin
      tx_sh_q  <= fifo_mem[rptr_q];
      tx_cnt_q <= clkdiv_q - 16'd1;
      tx_idx_q <= '0;
    end else if (tx_st_q != StIdle) begin
      if (tx_tick) begin
        tx_cnt_q <= clkdiv_q - 16'd1;
        if (tx_st_q == StData) begin
          tx_sh_q  <= tx_sh_q >> 1;
          tx_idx_q <= tx_idx_q + 3'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end
    end
  end

`ifdef FEMTOSOC_UART_RX_EN
  logic        rx_s1_q, rx_s2_q, rx_tick, rx_done;
  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_sh_q;
  logic        rx_valid_q, rx_overrun_q;
  logic [7:0]  rx_byte_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_st_q <= StIdle;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d;
    end
  end

  assign rx_tick = rx_cnt_q == '0;

  always_comb begin
    rx_st_d = rx_st_q;
    unique case (rx_st_q)
      StIdle:  if (!rx_s2_q) rx_st_d = StStart;
      StStart: if (rx_tick) rx_st_d = rx_s2_q ? StIdle : StData;
      StData:  if (rx_tick && rx_idx_q == 3'd7) rx_st_d = StStop;
      StStop:  if (rx_tick) rx_st_d = StIdle;
      default: rx_st_d = StIdle;
    endcase
  end

  always_comb begin
    rx_done = (rx_st_q == StStop) && rx_tick && rx_s2_q;
  end

  // Idle keeps the half-bit delay preloaded so the start bit is checked mid-bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_cnt_q <= '0;
      rx_idx_q <= '0;
      rx_sh_q  <= '0;
    end else if (rx_st_q == StIdle) begin
      rx_cnt_q <= {1'b0, clkdiv_q[15:1]} - 16'd1;
      rx_idx_q <= '0;
    end else if (rx_tick) begin
      rx_cnt_q <= clkdiv_q - 16'd1;
      if (rx_st_q == StData) begin
        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
        rx_idx_q <= rx_idx_q + 3'd1;
      end
    end else begin
      rx_cnt_q <= rx_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      if (rx_done && (!rx_valid_q || data_rd_ack)) begin
        rx_byte_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (data_rd_ack) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_done && rx_valid_q && !data_rd_ack) begin
        rx_overrun_q <= 1'b1;
      end else if (ack && off_stat && iomem_wstrb[0] && iomem_wdata[3]) begin
        rx_overrun_q <= 1'b0;
      end
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_byte    = rx_byte_q;
`else
  logic unused_rx;
  assign unused_rx  = uart_rx ^ data_rd_ack;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = '0;
`endif

endmodule

// File: tb/tb_femtosoc_uart.sv
// Randomized self-checking bench for femtosoc_uart: a bus driver, a behavioural UART line
// decoder/encoder and expected-byte queues built from the register map.
module tb_femtosoc_uart;
  localparam logic [31:0] Base = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cur_div = 104;
  bit         mon_en = 1'b1;
  logic [7:0] tx_seen[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  femtosoc_uart dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bus transaction; lat is the number of edges until ready (0 = never acknowledged).
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int budget, output logic [31:0] rdata, output int lat);
    lat = 0;
    rdata = '0;
    @(posedge clk);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin
        lat = i;
        rdata = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    bus(Base | {24'h0, off}, 32'h0, 4'h0, 50, d, lat);
    check(tag, {32'(lat != 0), d}, {32'd1, exp});
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] data,
                    input int budget);
    logic [31:0] d;
    int lat;
    bus(Base | {24'h0, off}, data, 4'hF, budget, d, lat);
    check(tag, 64'(lat != 0), 64'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int lat;
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus(Base | 32'h08, 32'h0, 4'h0, 10, d, lat);
      if (lat != 0 && d[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("tx_idle_wait", 64'(ok), 64'd1);
  endtask

  task automatic wait_tx_low(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_count"}, 64'(tx_seen.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_seen.size(); i++) begin
      check(tag, 64'(tx_seen[i]), 64'(exp_q[i]));
    end
    tx_seen.delete();
    exp_q.delete();
  endtask

  task automatic rx_send(input logic [7:0] b, input int d);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (d) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (d) @(negedge clk);
  endtask

  // Line decoder: samples each bit at its centre using the bench's own divider.
  initial begin : tx_monitor
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && resetn && uart_tx === 1'b0) begin
        logic [7:0] b;
        logic good;
        int d;
        d = cur_div;
        b = '0;
        repeat (d / 2) @(posedge clk);
        #1;
        good = (uart_tx === 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (d) @(posedge clk);
          #1;
          b[k] = uart_tx;
        end
        repeat (d) @(posedge clk);
        #1;
        good = good && (uart_tx === 1'b1);
        if (good && mon_en) tx_seen.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    int lat;
    bit found;
    logic [39:0] wave, wexp;
    logic [9:0] frame;
    logic [7:0] b;
    int n, dv;
    logic [7:0] off;
    logic [31:0] v;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(iomem_ready), 64'd0);
    check("rst_rdata", 64'(iomem_rdata), 64'd0);
    check("rst_tx", 64'(uart_tx), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    rd_chk("stat_reset", 8'h08, 32'h2);
    rd_chk("div_reset", 8'h04, 32'd104);
    rd_chk("data_empty", 8'h00, 32'hFFFF_FFFF);
    bus(Base, 32'h0, 4'h0, 10, d, lat);
    check("lat_reg", 64'(lat), 64'd1);

    // Divider clamp, including random values.
    for (int i = 0; i < 6; i++) begin
      v = (i < 4) ? 32'(i) : 32'($urandom_range(0, 300));
      wr("div_wr", 8'h04, v, 10);
      rd_chk("div_clamp", 8'h04, (v < 2) ? 32'd2 : v);
    end

    // Unmapped offsets and unselected addresses.
    bus(Base | 32'h10, 32'h0, 4'h0, 10, d, lat);
    check("other_rd", {32'(lat), d}, {32'd2, 32'h0});
    for (int i = 0; i < 3; i++) begin
      off = 8'h0C + 8'(4 * $urandom_range(0, 60));
      bus(Base | {24'h0, off}, $urandom, 4'hF, 10, d, lat);
      check("other_wr_lat", 64'(lat), 64'd2);
      bus(Base | {24'h0, off}, 32'h0, 4'h0, 10, d, lat);
      check("other_rd_rand", {32'(lat), d}, {32'd2, 32'h0});
    end
    bus(Base + 32'h100, 32'h0, 4'h0, 20, d, lat);
    check("unsel_100", 64'(lat), 64'd0);
    bus(32'h0300_0000, 32'h5, 4'hF, 20, d, lat);
    check("unsel_far", 64'(lat), 64'd0);

    // Exact waveform of 0x55 at divider 4.
    wr("div4", 8'h04, 32'd4, 10);
    cur_div = 4;
    wr("data55", 8'h00, 32'h55, 10);
    wait_tx_low(found);
    check("start_found", 64'(found), 64'd1);
    wave = '0;
    wave[0] = uart_tx;
    for (int t = 1; t < 40; t++) begin
      @(posedge clk);
      #1;
      wave[t] = uart_tx;
    end
    frame = {1'b1, 8'h55, 1'b0};
    for (int t = 0; t < 40; t++) wexp[t] = frame[t / 4];
    check("frame55", 64'(wave), 64'(wexp));
    rd_chk("stat_after55", 8'h08, 32'h2);
    exp_q.push_back(8'h55);
    cmp_frames("mon55");

    // Five writes against a depth-4 FIFO while the first byte is on the line.
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
    wr("fifo_w0", 8'h00, 32'(exp_q[0]), 10);
    wait_tx_low(found);
    check("fifo_start", 64'(found), 64'd1);
    for (int i = 1; i < 4; i++) begin
      bus(Base, 32'(exp_q[i]), 4'h1, 10, d, lat);
      check("fifo_w_lat", 64'(lat), 64'd1);
    end
    bus(Base, 32'(exp_q[4]), 4'h1, 10, d, lat);
    check("fifo_w4_lat", 64'(lat), 64'd1);
    rd_chk("stat_full", 8'h08, 32'h1);
    b = 8'($urandom);
    exp_q.push_back(b);
    bus(Base, 32'(b), 4'h1, 200, d, lat);
    check("fifth_stalled", 64'(lat > 3), 64'd1);
    wait_idle();
    cmp_frames("fifo_order");

    // Random traffic at random dividers.
    for (int r = 0; r < 3; r++) begin
      dv = $urandom_range(3, 8);
      wr("rnd_div", 8'h04, 32'(dv), 10);
      cur_div = dv;
      n = $urandom_range(2, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr("rnd_data", 8'h00, 32'(b), 500);
        if ($urandom_range(0, 1) == 1) rd_chk("rnd_div_rd", 8'h04, 32'(dv));
      end
      wait_idle();
      cmp_frames("rnd_frames");
    end

    // Receive path.
    wr("div8", 8'h04, 32'd8, 10);
    cur_div = 8;
`ifdef FEMTOSOC_UART_RX_EN
    rx_send(8'hA3, 8);
    repeat (4) @(posedge clk);
    rd_chk("rx_a3", 8'h00, 32'hA3);
    rd_chk("rx_empty", 8'h00, 32'hFFFF_FFFF);
    b = 8'($urandom);
    rx_send(b, 8);
    rx_send(8'($urandom), 8);
    repeat (4) @(posedge clk);
    rd_chk("stat_ovr", 8'h08, 32'hE);
    rd_chk("rx_first", 8'h00, 32'(b));
    wr("ovr_clr", 8'h08, 32'h8, 10);
    rd_chk("stat_clr", 8'h08, 32'h2);
`else
    rx_send(8'hA3, 8);
    repeat (4) @(posedge clk);
    rd_chk("rx_ignored", 8'h00, 32'hFFFF_FFFF);
    rd_chk("stat_norx", 8'h08, 32'h2);
`endif

    // Reset in the middle of a frame, with a request pending.
    wr("div4b", 8'h04, 32'd4, 10);
    cur_div = 4;
    wr("data_rst", 8'h00, 32'hC3, 10);
    wait_tx_low(found);
    check("rst_frame_start", 64'(found), 64'd1);
    repeat (10) @(posedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    iomem_valid = 1'b1;
    iomem_addr = Base | 32'h08;
    iomem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("rst_mid_tx", 64'(uart_tx), 64'd1);
    check("rst_mid_ready", 64'(iomem_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rst_mid_rdata", 64'(iomem_rdata), 64'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd_chk("stat_post_rst", 8'h08, 32'h2);
    rd_chk("div_post_rst", 8'h04, 32'd104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
